// File: rtl/divu_seq.sv
// -----------------------------------------------------------------------------
// divu_seq -- sequential radix-2 restoring divider, one quotient bit per clock.
//
// A multi-cycle execution unit that sits beside the ALU. The pipeline stalls
// while busy is high and picks up q/r/dz on the single-cycle done pulse.
//
// Optional feature macro: DIVU_SIGNED_EN
//   defined   : sign=1 selects two's-complement operands. Magnitudes are divided
//               and the sign fixup is applied while leaving FINISH, so latency
//               is unchanged. The quotient truncates toward zero and the
//               remainder takes the sign of a.
//   undefined : the sign input is ignored and every operation is unsigned.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   CNT_W   iteration counter width, derived from WIDTH
//
// Ports
//   clk     in   1      rising-edge clock
//   resetn  in   1      asynchronous active-low reset
//   start   in   1      request, accepted only when idle (busy==0, done==0)
//   abort   in   1      cancel the operation in flight, no done pulse
//   sign    in   1      signed operation (DIVU_SIGNED_EN builds only)
//   a       in   WIDTH  dividend, sampled on the accepting edge
//   b       in   WIDTH  divisor, sampled on the accepting edge
//   q       out  WIDTH  quotient, held until the next completed operation
//   r       out  WIDTH  remainder, held until the next completed operation
//   busy    out  1      operation in progress (CALC or FINISH)
//   done    out  1      one-cycle pulse, q/r/dz valid
//   dz      out  1      divide-by-zero flag of the completed operation
//
// Timing: start accepted at edge 0 -> done high in the cycle after edge
// WIDTH+1. A zero divisor skips CALC, so done is high after edge 1.
// -----------------------------------------------------------------------------
module divu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH:0]   rem_q;      // partial remainder, one guard bit
    logic [WIDTH-1:0] quo_q;      // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [CNT_W-1:0] cnt_q;      // iterations left
    logic             dz_pend_q;  // zero divisor seen at accept

    logic             accept;
    logic             b_zero;
    logic             finish_fire;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    // A start that arrives in the done cycle is dropped. The requester has to
    // hold or repeat it for one more cycle.
    assign accept      = start && (state_q == S_IDLE) && !done;
    assign b_zero      = (b == '0);
    assign finish_fire = (state_q == S_FINISH) && !abort;

`ifdef DIVU_SIGNED_EN
    logic sa;
    logic sb;
    logic neg_quo_q;
    logic neg_rem_q;

    assign sa    = sign & a[WIDTH-1];
    assign sb    = sign & b[WIDTH-1];
    // The magnitude of MIN wraps to MIN. Read as unsigned that is 2^(WIDTH-1),
    // which is correct, so MIN / -1 gives q=MIN, r=0 without a special case.
    assign mag_a = sa ? (~a + 1'b1) : a;
    assign mag_b = sb ? (~b + 1'b1) : b;
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign mag_a       = a;
    assign mag_b       = b;
`endif

    // One restoring step: shift {R,Q} left, then subtract if the divisor fits.
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign fits    = (shifted >= {1'b0, dvs_q});

    // Result formatting. A zero divisor never runs CALC, so quo_q still holds
    // |a|. That value becomes the remainder, and the sign fixup turns it back
    // into a.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        res_q = dz_pend_q ? '1    : quo_q;
        res_r = dz_pend_q ? quo_q : rem_q[WIDTH-1:0];
`ifdef DIVU_SIGNED_EN
        if (neg_quo_q && !dz_pend_q) res_q = ~quo_q + 1'b1;
        if (neg_rem_q)               res_r = ~res_r + 1'b1;
`endif
    end

    // Next-state logic and the busy output.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = b_zero ? S_FINISH : S_CALC;
            end
            S_CALC: begin
                if (abort)                    state_d = S_IDLE;
                else if (cnt_q == CNT_W'(1))  state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            dz_pend_q <= 1'b0;
            q         <= '0;
            r         <= '0;
            dz        <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: every register here uses non-blocking assignment, so each
            // right-hand side sees the values from before the edge.
            state_q <= state_d;
            done    <= finish_fire;

            if (accept) begin
                rem_q     <= '0;
                quo_q     <= mag_a;
                dvs_q     <= mag_b;
                cnt_q     <= CNT_W'(WIDTH);
                dz_pend_q <= b_zero;
            end else if (state_q == S_CALC && !abort) begin
                rem_q <= fits ? trial : shifted;
                quo_q <= {quo_q[WIDTH-2:0], fits};
                cnt_q <= cnt_q - 1'b1;
            end

            // When abort wins, FINISH never fires and the previous results stay.
            if (finish_fire) begin
                q  <= res_q;
                r  <= res_r;
                dz <= dz_pend_q;
            end
        end
    end

`ifdef DIVU_SIGNED_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_quo_q <= sa ^ sb;
            neg_rem_q <= sa;
        end
    end
`endif

endmodule

// File: tb/tb_divu_seq.sv
// -----------------------------------------------------------------------------
// tb_divu_seq -- self-checking bench for divu_seq. It drives one WIDTH=8
// instance and one WIDTH=32 instance.
// Each accepted operation pushes its expected result, computed by a reference
// model, onto a per-instance queue. A monitor pops the queue and compares on
// every done pulse. The directed steps also check latency, busy length and
// held outputs.
// -----------------------------------------------------------------------------
module tb_divu_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8, abort8, sign8, busy8, done8, dz8;
    logic [7:0] a8, b8, q8, r8;

    // WIDTH=32 instance
    logic        start32, abort32, sign32, busy32, done32, dz32;
    logic [31:0] a32, b32, q32, r32;

    divu_seq #(.WIDTH(8)) u_div8 (
        .clk(clk), .resetn(resetn), .start(start8), .abort(abort8), .sign(sign8),
        .a(a8), .b(b8), .q(q8), .r(r8), .busy(busy8), .done(done8), .dz(dz8)
    );

    divu_seq #(.WIDTH(32)) u_div32 (
        .clk(clk), .resetn(resetn), .start(start32), .abort(abort32), .sign(sign32),
        .a(a32), .b(b32), .q(q32), .r(r32), .busy(busy32), .done(done32), .dz(dz32)
    );

    res_t sb8[$];
    res_t sb32[$];
    int   done8_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer / and % on values widened to 64 bits.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        res_t   e;
        longint mask;
        longint as_v;
        longint bs_v;
        longint qq;
        longint rr;
        logic   signed_op;
`ifdef DIVU_SIGNED_EN
        signed_op = s;
`else
        signed_op = s & 1'b0;
`endif
        mask = (longint'(1) << w) - 1;
        as_v = {32'b0, a} & mask;
        bs_v = {32'b0, b} & mask;
        if (bs_v == 0) begin
            e.q  = mask[31:0];
            e.r  = as_v[31:0];
            e.dz = 1'b1;
        end else begin
            if (signed_op && as_v[w-1]) as_v = as_v - (longint'(1) << w);
            if (signed_op && bs_v[w-1]) bs_v = bs_v - (longint'(1) << w);
            qq   = as_v / bs_v;
            rr   = as_v % bs_v;
            e.q  = qq[31:0] & mask[31:0];
            e.r  = rr[31:0] & mask[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitors: compare on every done pulse, away from the rising edge.
    always @(negedge clk) begin
        if (resetn && done8) begin
            res_t e;
            done8_cnt++;
            check("sb8_expected_pending", 64'(sb8.size() != 0), 64'd1);
            if (sb8.size() != 0) begin
                e = sb8.pop_front();
                check("sb8_q",  64'(q8),  64'(e.q[7:0]));
                check("sb8_r",  64'(r8),  64'(e.r[7:0]));
                check("sb8_dz", 64'(dz8), 64'(e.dz));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && done32) begin
            res_t e;
            check("sb32_expected_pending", 64'(sb32.size() != 0), 64'd1);
            if (sb32.size() != 0) begin
                e = sb32.pop_front();
                check("sb32_q",  64'(q32),  64'(e.q));
                check("sb32_r",  64'(r32),  64'(e.r));
                check("sb32_dz", 64'(dz32), 64'(e.dz));
            end
        end
    end

    // Presents one start pulse that the DUT accepts at "edge 0". Returns #1
    // after edge 0.
    task automatic launch(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit expect_result);
        @(posedge clk);
        #1;
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; sign8 = s; start8 = 1'b1;
            if (expect_result) sb8.push_back(model(8, a, b, s));
        end else begin
            a32 = a; b32 = b; sign32 = s; start32 = 1'b1;
            if (expect_result) sb32.push_back(model(32, a, b, s));
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Call #1 after edge 0. Returns at the negedge of the done cycle.
    // lat is the index of the edge after which done was seen. busy_c counts
    // cycles with busy high.
    task automatic wait_done(input int w, output int lat, output int busy_c);
        bit found;
        found  = 1'b0;
        lat    = 0;
        busy_c = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if ((w == 8) ? busy8 : busy32) busy_c++;
            if ((w == 8) ? done8 : done32) found = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check("done_seen", 64'(found), 64'd1);
    endtask

    initial begin
        int lat;
        int bc;
        int cnt_before;
        logic [31:0] ra;
        logic [31:0] rb;

        resetn = 1'b0;
        start8 = 0; abort8 = 0; sign8 = 0; a8 = '0; b8 = '0;
        start32 = 0; abort32 = 0; sign32 = 0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",    64'(q8),    64'd0);
        check("rst_r",    64'(r8),    64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_dz",   64'(dz8),   64'd0);
        resetn = 1'b1;

        // 1: 200/7 -> 28 r 4, done after edge 9, busy 9 cycles.
        launch(8, 32'd200, 32'd7, 1'b0, 1'b1);
        wait_done(8, lat, bc);
        check("t1_latency", 64'(lat), 64'd9);
        check("t1_busy",    64'(bc),  64'd9);
        check("t1_q",       64'(q8),  64'd28);
        check("t1_r",       64'(r8),  64'd4);

        // 2: divide by zero -> done after edge 1, q=FF, r=a, dz=1.
        launch(8, 32'd5, 32'd0, 1'b0, 1'b1);
        wait_done(8, lat, bc);
        check("t2_latency", 64'(lat), 64'd1);
        check("t2_busy",    64'(bc),  64'd1);
        check("t2_q",       64'(q8),  64'hFF);
        check("t2_r",       64'(r8),  64'd5);
        check("t2_dz",      64'(dz8), 64'd1);

        // 3: start held high the whole time. Only one 100/3 result appears.
        // The start seen in the done cycle is dropped. The next cycle accepts 50/7.
        @(posedge clk);
        #1;
        a8 = 8'd100; b8 = 8'd3; sign8 = 1'b0; start8 = 1'b1;
        sb8.push_back(model(8, 32'd100, 32'd3, 1'b0));
        @(posedge clk);
        #1;
        wait_done(8, lat, bc);
        check("t3a_latency", 64'(lat), 64'd9);
        check("t3a_q",       64'(q8),  64'd33);
        check("t3a_r",       64'(r8),  64'd1);
        a8 = 8'd50; b8 = 8'd7;
        sb8.push_back(model(8, 32'd50, 32'd7, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done(8, lat, bc);
        check("t3b_latency", 64'(lat), 64'd9);
        check("t3b_q",       64'(q8),  64'd7);

        // 4a: abort during the 4th CALC cycle -> idle, no done, results kept.
        launch(8, 32'd9, 32'd2, 1'b0, 1'b0);
        cnt_before = done8_cnt;
        repeat (3) @(posedge clk);
        #1;
        abort8 = 1'b1;
        @(posedge clk);
        #1;
        abort8 = 1'b0;
        @(negedge clk);
        check("t4_busy_after_abort", 64'(busy8), 64'd0);
        check("t4_q_kept",           64'(q8),    64'd7);
        check("t4_r_kept",           64'(r8),    64'd1);
        check("t4_dz_kept",          64'(dz8),   64'd0);
        repeat (14) @(posedge clk);
        check("t4_no_done", 64'(done8_cnt), 64'(cnt_before));

        // 4b: the divider recovers after the abort.
        launch(8, 32'd9, 32'd2, 1'b0, 1'b1);
        wait_done(8, lat, bc);
        check("t4b_q", 64'(q8), 64'd4);

        // 4c: abort in FINISH beats completion (zero divisor reaches FINISH at once).
        launch(8, 32'd5, 32'd0, 1'b0, 1'b0);
        cnt_before = done8_cnt;
        abort8 = 1'b1;
        @(posedge clk);
        #1;
        abort8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t4c_no_done", 64'(done8_cnt), 64'(cnt_before));
        check("t4c_q_kept",  64'(q8),  64'd4);
        check("t4c_dz_kept", 64'(dz8), 64'd0);

        // 4d: asynchronous reset mid-CALC clears the outputs at once.
        launch(8, 32'd200, 32'd7, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("t4d_q",    64'(q8),    64'd0);
        check("t4d_r",    64'(r8),    64'd0);
        check("t4d_busy", 64'(busy8), 64'd0);
        check("t4d_done", 64'(done8), 64'd0);
        #2;
        resetn = 1'b1;

        // 5: sign=1 stimulus. The expected values depend on the build.
        launch(8, 32'h0000_00F9, 32'd2, 1'b1, 1'b1);
        wait_done(8, lat, bc);
`ifdef DIVU_SIGNED_EN
        check("t5a_q", 64'(q8), 64'hFD);
        check("t5a_r", 64'(r8), 64'hFF);
`else
        check("t5a_q", 64'(q8), 64'd124);
        check("t5a_r", 64'(r8), 64'd1);
`endif
        launch(8, 32'h0000_0080, 32'h0000_00FF, 1'b1, 1'b1);
        wait_done(8, lat, bc);
`ifdef DIVU_SIGNED_EN
        check("t5b_q", 64'(q8), 64'h80);
        check("t5b_r", 64'(r8), 64'h00);
`else
        check("t5b_q", 64'(q8), 64'h00);
        check("t5b_r", 64'(r8), 64'h80);
`endif

        // 6: random sweep on both widths, with zero, tiny and larger-than-a divisors.
        for (int w_sel = 0; w_sel < 2; w_sel++) begin
            int w;
            int n_ops;
            w     = (w_sel == 0) ? 8 : 32;
            n_ops = (w_sel == 0) ? 600 : 250;
            for (int i = 0; i < n_ops; i++) begin
                int sel;
                ra  = $urandom;
                rb  = $urandom;
                sel = $urandom_range(0, 9);
                if (w == 8) begin
                    ra = ra & 32'hFF;
                    rb = rb & 32'hFF;
                end
                if (sel == 0)      rb = 32'd0;
                else if (sel == 1) rb = 32'($urandom_range(1, 3));
                else if (sel == 2) rb = (ra == 32'hFFFF_FFFF || (w == 8 && ra == 32'hFF)) ? ra : ra + 1;
                else if (sel == 3) rb = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
                launch(w, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
                wait_done(w, lat, bc);
            end
        end

        repeat (2) @(posedge clk);
        check("sb8_drained",  64'(sb8.size()),  64'd0);
        check("sb32_drained", 64'(sb32.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
